// File: rtl/reduce_instr_gen.sv
// reduce_instr_gen: per-node collective instruction stage.
// Accepts one flit from the local core and looks up its communicator entry by
// contextId. It then issues one or more routed flits whose destinations follow
// the flit's algorithm type.
//
// Flit layout (FlitWidth = 73):
//   [72] valid  [71:64] tag  [63:55] dst  [54:46] src  [45:44] algtype
//   [43:40] contextId  [39:32] op  [31:0] payload
// packetOut appends the children field above the flit, at [FlitWidth +: ChildrenWidth].
// The first issued flit is registered on the clock edge after the accept edge.
module reduce_instr_gen #(
  parameter int FlitWidth      = 73,
  parameter int ChildrenWidth  = 3,
  parameter int LgNumProcs     = 3,
  parameter int RankWidth      = 9,
  parameter int CtxEntries     = 4,
  parameter int CommTableWidth = 42,
  parameter int RootRank       = 0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [FlitWidth-1:0]               packetIn,
  output logic                               in_ready,
  output logic [FlitWidth+ChildrenWidth-1:0] packetOut,
  input  logic                               out_ready,
  input  logic                               cfg_we,
  input  logic                               cfg_sel,
  input  logic [LgNumProcs-1:0]              cfg_addr,
  input  logic [CommTableWidth-1:0]          cfg_data,
  output logic                               err_ctx
);

  localparam int ValidBit  = FlitWidth - 1;
  localparam int TagLsb    = FlitWidth - 9;
  localparam int DstLsb    = TagLsb - RankWidth;
  localparam int SrcLsb    = DstLsb - RankWidth;
  localparam int AlgLsb    = SrcLsb - 2;
  localparam int CtxLsb    = AlgLsb - 4;
  localparam int OutWidth  = FlitWidth + ChildrenWidth;
  localparam int RankDepth = 1 << LgNumProcs;
  localparam int CtxIdxW   = (CtxEntries > 1) ? $clog2(CtxEntries) : 1;
  localparam int StepW     = (LgNumProcs > ChildrenWidth) ? LgNumProcs : ChildrenWidth;

  typedef struct packed {
    logic [RankWidth-1:0]     local_rank;
    logic [ChildrenWidth-1:0] children;
    logic [LgNumProcs-1:0]    lg_comm;
    logic [RankWidth-1:0]     parent;
    logic [RankWidth-1:0]     r2;
    logic [RankWidth-1:0]     next;
  } comm_t;

  typedef enum logic [1:0] {ALG_TREE, ALG_RING, ALG_RDBL, ALG_BCAST} alg_e;
  typedef enum logic {IDLE, ISSUE} state_e;

  state_e               state_q, state_d;
  logic [FlitWidth-1:0] flit_q, flit_d;
  comm_t                entry_q, entry_d;
  logic [StepW-1:0]     n_q, n_d;
  logic [StepW-1:0]     k_q, k_d;
  logic                 self_q, self_d;
  logic [OutWidth-1:0]  out_q, out_d;
  logic                 err_q, err_d;

  logic [RankWidth-1:0] rank_q [RankDepth];
  comm_t                comm_q [CtxEntries];

  logic [3:0]               in_ctx;
  logic                     ctx_ok;
  logic                     accept;
  comm_t                    in_entry;
  logic [StepW-1:0]         in_n;
  logic [RankWidth-1:0]     step_bit;
  logic [RankWidth-1:0]     lg_mask;
  logic [RankWidth-1:0]     dst_idx;
  logic [RankWidth-1:0]     step_dst;
  logic [ChildrenWidth-1:0] step_child;
  logic [ChildrenWidth-1:0] remaining;
  logic                     last_step;
  logic [OutWidth-1:0]      step_flit;
  logic                     unused_bits;

  assign packetOut   = out_q;
  assign err_ctx     = err_q;
  assign unused_bits = ^{flit_q[ValidBit], flit_q[DstLsb +: RankWidth], entry_q.r2,
                         dst_idx[RankWidth-1:LgNumProcs]};

  // Input side: handshake, context check and step count of the offered flit.
  always_comb begin
    in_ctx   = packetIn[CtxLsb +: 4];
    ctx_ok   = int'(in_ctx) < CtxEntries;
    in_entry = comm_q[in_ctx[CtxIdxW-1:0]];
    in_ready = !rst && (state_q == IDLE) && (!out_q[ValidBit] || out_ready);
    accept   = packetIn[ValidBit] && in_ready;
    case (alg_e'(packetIn[AlgLsb +: 2]))
      ALG_RDBL:  in_n = StepW'(in_entry.lg_comm);
      ALG_BCAST: in_n = StepW'(in_entry.children);
      default:   in_n = StepW'(1);
    endcase
  end

  // Destination and children field of the current issue step.
  always_comb begin
    // NOTE: every combinational output gets a default first so that no path
    // through the case statements leaves it unassigned and infers a latch.
    dst_idx    = entry_q.local_rank;
    step_child = '0;
    step_bit   = RankWidth'(1) << k_q;
    lg_mask    = (RankWidth'(1) << entry_q.lg_comm) - RankWidth'(1);
    remaining  = ChildrenWidth'(n_q - k_q - StepW'(1));
    last_step  = self_q || (k_q == n_q - StepW'(1));
    if (!self_q) begin
      case (alg_e'(flit_q[AlgLsb +: 2]))
        ALG_TREE: begin
          // The root has no parent; it addresses itself.
          if (entry_q.local_rank != RankWidth'(RootRank)) dst_idx = entry_q.parent;
          step_child = entry_q.children;
        end
        ALG_RING: begin
          // The last rank of the ring wraps back to the root.
          dst_idx = (entry_q.local_rank == lg_mask) ? RankWidth'(RootRank) : entry_q.next;
        end
        ALG_RDBL: begin
          dst_idx    = entry_q.local_rank ^ step_bit;
          step_child = remaining;
        end
        default: begin
          dst_idx    = (entry_q.local_rank + step_bit) & lg_mask;
          step_child = remaining;
        end
      endcase
    end
    step_dst  = rank_q[dst_idx[LgNumProcs-1:0]];
    step_flit = {step_child, 1'b1, flit_q[TagLsb +: 8] + 8'(k_q), step_dst,
                 flit_q[DstLsb-1:0]};
  end

  // Next-state logic: accept in IDLE, one output load per free output slot in ISSUE.
  always_comb begin
    state_d = state_q;
    flit_d  = flit_q;
    entry_d = entry_q;
    n_d     = n_q;
    k_d     = k_q;
    self_d  = self_q;
    err_d   = 1'b0;
    // A completed handshake empties the output register.
    out_d   = out_ready ? '0 : out_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (ctx_ok) begin
            flit_d  = packetIn;
            entry_d = in_entry;
            n_d     = in_n;
            k_d     = '0;
            self_d  = (in_n == '0);
            state_d = ISSUE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (!out_q[ValidBit] || out_ready) begin
          out_d = step_flit;
          if (last_step) state_d = IDLE;
          else           k_d     = k_q + StepW'(1);
        end
      end
    endcase
  end

  // State, output and table registers; tables are written from the cfg port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      flit_q  <= '0;
      entry_q <= '0;
      n_q     <= '0;
      k_q     <= '0;
      self_q  <= 1'b0;
      out_q   <= '0;
      err_q   <= 1'b0;
      // NOTE: the tables are small register files that must read as zero after
      // reset, so they are cleared here rather than left as uninitialised RAM.
      for (int i = 0; i < RankDepth; i++)  rank_q[i] <= '0;
      for (int i = 0; i < CtxEntries; i++) comm_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      flit_q  <= flit_d;
      entry_q <= entry_d;
      n_q     <= n_d;
      k_q     <= k_d;
      self_q  <= self_d;
      out_q   <= out_d;
      err_q   <= err_d;
      if (cfg_we) begin
        if (!cfg_sel) begin
          rank_q[cfg_addr] <= cfg_data[RankWidth-1:0];
        end else if (int'(cfg_addr) < CtxEntries) begin
          comm_q[cfg_addr[CtxIdxW-1:0]] <= comm_t'(cfg_data);
        end
      end
    end
  end

endmodule

// File: tb/tb_reduce_instr_gen.sv
// Self-checking bench for reduce_instr_gen: a reference model pushes expected
// flits into a queue when a flit is offered, and a monitor pops and compares on
// every output handshake.
module tb_reduce_instr_gen;

  localparam int FW = 73;
  localparam int OW = 76;

  logic          clk = 1'b0;
  logic          rst;
  logic [FW-1:0] packet_in;
  logic          in_ready;
  logic [OW-1:0] packet_out;
  logic          out_ready;
  logic          cfg_we;
  logic          cfg_sel;
  logic [2:0]    cfg_addr;
  logic [41:0]   cfg_data;
  logic          err_ctx;

  always #5 clk = ~clk;

  reduce_instr_gen dut (
    .clk       (clk),
    .rst       (rst),
    .packetIn  (packet_in),
    .in_ready  (in_ready),
    .packetOut (packet_out),
    .out_ready (out_ready),
    .cfg_we    (cfg_we),
    .cfg_sel   (cfg_sel),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .err_ctx   (err_ctx)
  );

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [OW-1:0] exp_q [$];
  logic [OW-1:0] mon_exp;
  logic [OW-1:0] held;
  logic [8:0]    rank_m [8];
  logic [41:0]   comm_m [4];

  task automatic check(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor: compare every handshaken output flit.
  always @(negedge clk) begin
    if (!rst && packet_out[FW-1] && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", packet_out, '0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("scoreboard", packet_out, mon_exp);
      end
    end
  end

  function automatic logic [FW-1:0] mk(input logic [7:0] tag, input logic [3:0] ctx,
                                       input logic [1:0] alg);
    return {1'b1, tag, 9'h1AB, 9'(tag * 3 + 1), alg, ctx, 8'(tag ^ 8'h5A), $urandom()};
  endfunction

  function automatic logic [OW-1:0] mk_out(input logic [FW-1:0] f, input int k,
                                           input logic [8:0] dst, input logic [2:0] ch);
    logic [7:0] t;
    t = f[71:64] + 8'(k);
    return {ch, 1'b1, t, dst, f[54:0]};
  endfunction

  // Reference model: expected output flits for input flit f.
  task automatic push_expected(input logic [FW-1:0] f);
    logic [41:0] e;
    logic [8:0]  loc, par, nxt, idx;
    logic [2:0]  ch, lg, c;
    logic [1:0]  alg;
    int          n;
    e   = comm_m[f[41:40]];
    loc = e[41:33]; ch = e[32:30]; lg = e[29:27]; par = e[26:18]; nxt = e[8:0];
    alg = f[45:44];
    case (alg)
      2'd2:    n = int'(lg);
      2'd3:    n = int'(ch);
      default: n = 1;
    endcase
    if (n == 0) begin
      exp_q.push_back(mk_out(f, 0, rank_m[loc[2:0]], 3'd0));
    end else begin
      for (int k = 0; k < n; k++) begin
        case (alg)
          2'd0: begin idx = (loc == 9'd0) ? loc : par; c = ch; end
          2'd1: begin idx = (int'(loc) == (1 << lg) - 1) ? 9'd0 : nxt; c = 3'd0; end
          2'd2: begin idx = loc ^ 9'(1 << k); c = 3'(n - 1 - k); end
          default: begin idx = 9'((int'(loc) + (1 << k)) % (1 << lg)); c = 3'(n - 1 - k); end
        endcase
        exp_q.push_back(mk_out(f, k, rank_m[idx[2:0]], c));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [FW-1:0] f, input bit expect_ok);
    bit done;
    done = 1'b0;
    if (expect_ok) push_expected(f);
    packet_in = f;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      tick();
    end
    packet_in = '0;
    check("accept", OW'(done), OW'(1));
  endtask

  task automatic cfg_rank(input int a, input logic [8:0] v);
    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 3'(a); cfg_data = 42'(v);
    tick();
    cfg_we = 1'b0;
    rank_m[a] = v;
  endtask

  function automatic logic [41:0] comm_word(input logic [8:0] loc, input logic [2:0] ch,
                                            input logic [2:0] lg, input logic [8:0] par,
                                            input logic [8:0] nxt);
    return {loc, ch, lg, par, 9'h000, nxt};
  endfunction

  task automatic cfg_comm(input int a, input logic [41:0] w);
    cfg_we = 1'b1; cfg_sel = 1'b1; cfg_addr = 3'(a); cfg_data = w;
    tick();
    cfg_we = 1'b0;
    comm_m[a] = w;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check(tag, OW'(exp_q.size()), '0);
    repeat (3) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; packet_in = '0; out_ready = 1'b1;
    cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_data = '0;
    for (int i = 0; i < 8; i++) rank_m[i] = '0;
    for (int i = 0; i < 4; i++) comm_m[i] = '0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out", packet_out, 0);
    check("rst_err", err_ctx, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1);
    tick();

    for (int i = 0; i < 8; i++) cfg_rank(i, (i == 1) ? 9'o011 : 9'(i * 37 + 100));
    cfg_comm(0, comm_word(9'd3, 3'd2, 3'd3, 9'd1, 9'd4));
    cfg_comm(1, comm_word(9'd7, 3'd0, 3'd3, 9'd5, 9'd0));
    cfg_comm(2, comm_word(9'd0, 3'd5, 3'd3, 9'd2, 9'd1));
    cfg_comm(3, comm_word(9'd5, 3'd3, 3'd2, 9'd6, 9'd6));

    // T2: tree step to parent, first flit one edge after the accept edge.
    send(mk(8'd5, 4'd0, 2'd0), 1'b1);
    @(negedge clk);
    check("t2_pre_valid", packet_out[FW-1], 0);
    tick();
    @(negedge clk);
    check("t2_lat_valid", packet_out[FW-1], 1);
    check("t2_dst", packet_out[63:55], 9'o011);
    check("t2_tag", packet_out[71:64], 8'd5);
    wait_drain("t2_drain");

    // T3: recursive doubling, tag wraps past 255.
    send(mk(8'hFE, 4'd0, 2'd2), 1'b1);
    wait_drain("t3_drain");

    // T4: backpressure on step 0 holds the output stable.
    out_ready = 1'b0;
    send(mk(8'h40, 4'd0, 2'd2), 1'b1);
    for (int i = 0; i < 20 && !packet_out[FW-1]; i++) @(negedge clk);
    check("t4_valid", packet_out[FW-1], 1);
    held = packet_out;
    repeat (4) begin
      tick();
      @(negedge clk);
      check("t4_hold", packet_out, held);
      check("t4_in_ready", in_ready, 0);
    end
    tick();
    out_ready = 1'b1;
    wait_drain("t4_drain");

    // Comm write during ISSUE does not disturb the latched entry.
    out_ready = 1'b0;
    send(mk(8'h10, 4'd0, 2'd2), 1'b1);
    cfg_comm(0, comm_word(9'd3, 3'd2, 3'd1, 9'd1, 9'd4));
    out_ready = 1'b1;
    wait_drain("cfg_isolation");

    // Accept and write of the same ctx in one cycle: the accept sees the old entry.
    @(negedge clk);
    check("same_cycle_ready", in_ready, 1);
    tick();
    packet_in = mk(8'h20, 4'd0, 2'd2);
    push_expected(packet_in);
    cfg_we = 1'b1; cfg_sel = 1'b1; cfg_addr = 3'd0;
    cfg_data = comm_word(9'd3, 3'd2, 3'd3, 9'd1, 9'd4);
    tick();
    packet_in = '0; cfg_we = 1'b0; comm_m[0] = cfg_data;
    wait_drain("same_cycle_drain");
    send(mk(8'h30, 4'd0, 2'd2), 1'b1);
    wait_drain("new_entry_drain");

    // Back-to-back: tree root addresses itself, then a ring step to next.
    send(mk(8'd1, 4'd2, 2'd0), 1'b1);
    send(mk(8'd2, 4'd0, 2'd1), 1'b1);
    wait_drain("b2b_drain");

    // T5: out-of-range contexts are dropped with a one-cycle error pulse.
    send(mk(8'd3, 4'd6, 2'd0), 1'b0);
    @(negedge clk);
    check("t5_err_pulse", err_ctx, 1);
    tick();
    @(negedge clk);
    check("t5_err_clear", err_ctx, 0);
    check("t5_no_out", packet_out[FW-1], 0);
    tick();
    send(mk(8'd3, 4'd4, 2'd2), 1'b0);
    @(negedge clk);
    check("ctx4_err_pulse", err_ctx, 1);
    tick();

    // A flit with valid low has no effect.
    packet_in = mk(8'd9, 4'd0, 2'd2);
    packet_in[FW-1] = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("novalid_no_out", packet_out[FW-1], 0);
      check("novalid_ready", in_ready, 1);
      tick();
    end
    packet_in = '0;

    // T6: ring wrap to root, bcast with zero children, bcast fan-out, tree to parent.
    send(mk(8'd4, 4'd1, 2'd1), 1'b1);
    send(mk(8'd5, 4'd1, 2'd3), 1'b1);
    send(mk(8'd6, 4'd3, 2'd3), 1'b1);
    send(mk(8'd7, 4'd1, 2'd0), 1'b1);
    wait_drain("t6_drain");

    // T1: reset while step 1 of a recursive-doubling issue is pending.
    send(mk(8'd7, 4'd0, 2'd2), 1'b1);
    tick();
    check("t1_step0_out", packet_out[FW-1], 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t1_out_cleared", packet_out, 0);
    check("t1_in_ready", in_ready, 1);
    exp_q.delete();
    for (int i = 0; i < 8; i++) rank_m[i] = '0;
    for (int i = 0; i < 4; i++) comm_m[i] = '0;
    repeat (5) begin
      tick();
      @(negedge clk);
      check("t1_no_more", packet_out[FW-1], 0);
    end
    tick();
    // Cleared tables: root entry addressing itself at coordinate 0.
    send(mk(8'd9, 4'd0, 2'd0), 1'b1);
    wait_drain("post_reset_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
